// File: rtl/alu_pkg.sv
// Shared types and constants for the clocked ALU subsystem: issue FSM states,
// ALU opcode encodings and default datapath widths.
package alu_pkg;
  localparam int OP_W  = 8;
  localparam int RES_W = 8;

  typedef enum logic [1:0] {IDLE, SETTLE, RESULT} state_t;

  localparam logic [3:0] ADD  = 4'h0;
  localparam logic [3:0] SUB  = 4'h1;
  localparam logic [3:0] MUL  = 4'h2;
  localparam logic [3:0] DIV  = 4'h3;
  localparam logic [3:0] SHL  = 4'h4;
  localparam logic [3:0] SHR  = 4'h5;
  localparam logic [3:0] ROL  = 4'h6;
  localparam logic [3:0] ROR  = 4'h7;
  localparam logic [3:0] AND  = 4'h8;
  localparam logic [3:0] OR   = 4'h9;
  localparam logic [3:0] XOR  = 4'hA;
  localparam logic [3:0] NOR  = 4'hB;
  localparam logic [3:0] NAND = 4'hC;
  localparam logic [3:0] XNOR = 4'hD;
  localparam logic [3:0] GT   = 4'hE;
  localparam logic [3:0] EQ   = 4'hF;
endpackage

// File: rtl/alu_settle_cnt.sv
// Loadable down-counter that times the ALU settle window; zero flags expiry.
module alu_settle_cnt #(
  parameter int W = 4
)(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt <= '0;
    else if (load)               cnt <= load_val;
    else if (dec && cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/capture stage in front of the combinational ALU: holds operands,
// waits SETTLE_CYCLES edges, registers the result and hands it downstream.
module alu_issue_ctrl #(
  parameter int OP_W          = alu_pkg::OP_W,
  parameter int RES_W         = alu_pkg::RES_W,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 16
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_a,
  input  logic [OP_W-1:0]  in_b,
  input  logic [3:0]       in_sel,
  output logic [OP_W-1:0]  alu_a,
  output logic [OP_W-1:0]  alu_b,
  output logic [3:0]       alu_sel,
  input  logic [RES_W-1:0] alu_out,
  input  logic             alu_carry,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [RES_W-1:0] res_data,
  output logic             res_carry,
  output logic             res_zero,
  output logic [3:0]       res_sel,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);
  import alu_pkg::*;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES - 1);

  state_t state, state_nxt;
  logic   accept, res_hs, capture, cnt_zero;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SETTLE;
      end
      SETTLE: begin
        if (cnt_zero) begin
          capture   = 1'b1;
          state_nxt = RESULT;
        end
      end
      RESULT: begin
        // Draining the result frees the operand registers in the same cycle.
        in_ready = res_ready;
        if (res_ready) state_nxt = in_valid ? SETTLE : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = in_valid & in_ready;
  assign res_hs = (state == RESULT) & res_ready;
  assign busy   = (state != IDLE);

  alu_settle_cnt #(.W(4)) u_settle_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .load_val (SETTLE_LD),
    .dec      ((state == SETTLE) & ~cnt_zero),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      res_data  <= '0;
      res_carry <= 1'b0;
      res_zero  <= 1'b0;
      res_sel   <= '0;
      res_valid <= 1'b0;
      op_count  <= '0;
    end else begin
      state     <= state_nxt;
      res_valid <= (state_nxt == RESULT);
      if (accept) begin
        alu_a   <= in_a;
        alu_b   <= in_b;
        alu_sel <= in_sel;
      end
      if (capture) begin
        res_data  <= alu_out;
        res_carry <= alu_carry;
        res_zero  <= (alu_out == '0);
        res_sel   <= alu_sel;
      end
      if (res_hs) op_count <= op_count + 1'b1;
    end
  end
endmodule
